// File: rtl/adder_sat_pipe_if.sv
// Valid/ready operation and result channel for adder_sat_pipe.
// Master offers operations and consumes results; slave is the unit.
interface adder_sat_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             in_sat;
  logic             in_acc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_ovf;

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output in_sub,
    output in_sat,
    output in_acc,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sum,
    input  out_ovf
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  in_sub,
    input  in_sat,
    input  in_acc,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sum,
    output out_ovf
  );
endinterface

// File: rtl/adder_sat_pipe.sv
// Registered signed add/sub with wrap or saturate, accumulator operand,
// sticky overflow flag and saturating overflow counter.
module adder_sat_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  adder_sat_pipe_if.slave     io,
  output logic                ovf_sticky,
  output logic [CNT_W-1:0]    ovf_count
);

  localparam logic [WIDTH-1:0] MAX_V =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_V =
    {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] res;
  logic             sa;
  logic             sb;
  logic             sr;
  logic             ovf;
  logic             sat_hit;
  logic             accept;
  logic             release_out;
  logic             ovf_ev;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_sum_q;
  logic             out_ovf_q;

  assign io.in_ready  = !out_valid_q || io.out_ready;
  assign io.out_valid = out_valid_q;
  assign io.out_sum   = out_sum_q;
  assign io.out_ovf   = out_ovf_q;

  assign accept      = io.in_valid && io.in_ready;
  assign release_out = out_valid_q && io.out_ready;
  assign ovf_ev      = accept && ovf;

  always_comb begin
    op_b    = io.in_acc ? acc : io.in_b;
    raw     = '0;
    ovf     = 1'b0;
    sat_hit = 1'b0;
    res     = '0;

    // subtract via one's complement plus one so the minimum
    // value needs no special negation
    if (io.in_sub) begin
      raw = io.in_a + ~op_b + WIDTH'(1);
    end else begin
      raw = io.in_a + op_b;
    end

    sa = io.in_a[WIDTH-1];
    sb = op_b[WIDTH-1];
    sr = raw[WIDTH-1];

    if (io.in_sub) begin
      ovf = (sa != sb) && (sr != sa);
    end else begin
      ovf = (sa == sb) && (sr != sa);
    end

    sat_hit = io.in_sat && ovf;

    unique case (1'b1)
      sat_hit && !sa: res = MAX_V;
      sat_hit &&  sa: res = MIN_V;
      default:        res = raw;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_sum_q   <= res;
      out_ovf_q   <= ovf;
    end else if (release_out) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (accept) begin
      acc <= res;
    end else if (clr) begin
      acc <= '0;
    end
  end

  // clr wipes history but an overflow in the same cycle still counts
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else if (clr) begin
      ovf_sticky <= ovf_ev;
      ovf_count  <= ovf_ev ? CNT_W'(1) : '0;
    end else if (ovf_ev) begin
      ovf_sticky <= 1'b1;
      if (ovf_count != CNT_MAX) begin
        ovf_count <= ovf_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_adder_sat_pipe.sv
// Directed-vector bench for adder_sat_pipe.
// Covers wrap/sat, accumulate, backpressure, counter clamp, reset.
module tb_adder_sat_pipe;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  logic clr2;
  logic       sticky;
  logic [7:0] count;
  logic       sticky2;
  logic [1:0] count2;

  int total = 0;
  int bad   = 0;
  logic [7:0] seen[$];

  always #5 clk = ~clk;

  adder_sat_pipe_if #(.WIDTH(8)) m ();
  adder_sat_pipe_if #(.WIDTH(8)) m2 ();

  adder_sat_pipe #(.WIDTH(8), .CNT_W(8)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .io         (m.slave),
    .ovf_sticky (sticky),
    .ovf_count  (count)
  );

  adder_sat_pipe #(.WIDTH(8), .CNT_W(2)) u_dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr2),
    .io         (m2.slave),
    .ovf_sticky (sticky2),
    .ovf_count  (count2)
  );

  always @(posedge clk) begin
    if (rst_n && m.out_valid && m.out_ready)
      seen.push_back(m.out_sum);
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] a,
                     input logic [7:0] b,
                     input logic sub,
                     input logic sat,
                     input logic acc,
                     input logic c);
    m.in_valid = 1'b1;
    m.in_a     = a;
    m.in_b     = b;
    m.in_sub   = sub;
    m.in_sat   = sat;
    m.in_acc   = acc;
    clr        = c;
  endtask

  task automatic idle();
    m.in_valid = 1'b0;
    clr        = 1'b0;
  endtask

  task automatic res(input string tag,
                     input logic [7:0] s,
                     input logic o);
    chk({tag, "_v"}, 64'(m.out_valid), 64'd1);
    chk({tag, "_s"}, 64'(m.out_sum), 64'(s));
    chk({tag, "_o"}, 64'(m.out_ovf), 64'(o));
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    clr2  = 1'b0;
    idle();
    m.in_a = '0; m.in_b = '0;
    m.in_sub = 0; m.in_sat = 0; m.in_acc = 0;
    m.out_ready = 1'b1;
    m2.in_valid = 1'b0;
    m2.in_a = '0; m2.in_b = '0;
    m2.in_sub = 0; m2.in_sat = 0; m2.in_acc = 0;
    m2.out_ready = 1'b1;
    #1;
    step();
    step();

    chk("rst_valid", 64'(m.out_valid), 64'd0);
    chk("rst_sum", 64'(m.out_sum), 64'd0);
    chk("rst_ovf", 64'(m.out_ovf), 64'd0);
    chk("rst_sticky", 64'(sticky), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ready", 64'(m.in_ready), 64'd1);
    rst_n = 1'b1;

    put(8'd10, 8'd20, 0, 0, 0, 0);
    step();
    res("add", 8'd30, 0);
    idle();
    step();
    chk("release", 64'(m.out_valid), 64'd0);

    put(8'h7F, 8'h01, 0, 0, 0, 0); step(); res("pos_wrap", 8'h80, 1);
    put(8'h7F, 8'h01, 0, 1, 0, 0); step(); res("pos_sat", 8'h7F, 1);
    chk("cnt2", 64'(count), 64'd2);
    chk("sticky1", 64'(sticky), 64'd1);

    put(8'h80, 8'h01, 1, 0, 0, 0); step(); res("neg_wrap", 8'h7F, 1);
    put(8'h80, 8'h01, 1, 1, 0, 0); step(); res("neg_sat", 8'h80, 1);
    put(8'h00, 8'h80, 1, 1, 0, 0); step(); res("min_sub", 8'h7F, 1);
    put(8'hF6, 8'h0A, 0, 0, 0, 0); step(); res("zero1", 8'h00, 0);
    put(8'h7F, 8'h7F, 1, 0, 0, 0); step(); res("zero2", 8'h00, 0);
    put(8'hFF, 8'h01, 0, 0, 0, 0); step(); res("zero3", 8'h00, 0);
    chk("cnt5", 64'(count), 64'd5);

    put(8'd100, 8'd0, 0, 0, 0, 0); step(); res("acc1", 8'd100, 0);
    put(8'd50, 8'hAA, 0, 1, 1, 1); step(); res("acc2", 8'd127, 1);
    chk("acc2_cnt", 64'(count), 64'd1);
    chk("acc2_sticky", 64'(sticky), 64'd1);
    put(8'hE5, 8'h55, 0, 0, 1, 0); step(); res("acc3", 8'd100, 0);
    chk("acc3_cnt", 64'(count), 64'd1);
    idle();
    step();

    seen.delete();
    m.out_ready = 1'b0;
    put(8'd1, 8'd2, 0, 0, 0, 0);
    step();
    res("bp_x", 8'd3, 0);
    put(8'd5, 8'd5, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready", 64'(m.in_ready), 64'd0);
      step();
      chk("bp_hold", 64'(m.out_sum), 64'd3);
    end
    m.out_ready = 1'b1;
    step();
    res("bp_y", 8'd10, 0);
    idle();
    step();
    chk("bp_n", 64'(seen.size()), 64'd2);
    if (seen.size() == 2) begin
      chk("bp_q0", 64'(seen[0]), 64'd3);
      chk("bp_q1", 64'(seen[1]), 64'd10);
    end

    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_cnt", 64'(count), 64'd0);
    chk("clr_sticky", 64'(sticky), 64'd0);
    put(8'd4, 8'd0, 0, 0, 1, 0);
    step();
    res("clr_acc", 8'd4, 0);
    idle();

    m2.in_a = 8'h7F;
    m2.in_b = 8'h01;
    m2.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) step();
    m2.in_valid = 1'b0;
    chk("cnt_clamp", 64'(count2), 64'd3);
    chk("cnt_sticky", 64'(sticky2), 64'd1);

    m.out_ready = 1'b0;
    put(8'd7, 8'd8, 0, 0, 0, 0);
    step();
    res("held", 8'd15, 0);
    idle();
    rst_n = 1'b0;
    step();
    chk("mid_valid", 64'(m.out_valid), 64'd0);
    chk("mid_sum", 64'(m.out_sum), 64'd0);
    chk("mid_ovf", 64'(m.out_ovf), 64'd0);
    chk("mid_ready", 64'(m.in_ready), 64'd1);
    chk("mid_cnt2", 64'(count2), 64'd0);
    rst_n = 1'b1;
    m.out_ready = 1'b1;
    put(8'd9, 8'd0, 0, 0, 1, 0);
    step();
    res("post_acc", 8'd9, 0);
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
